pipe_ctrl_pipeline: RTL and testbench
=====================================

Name: pipe_ctrl_pipeline

Overview:
- Sequential counterpart to the decode-stage control unit.
- Takes the decoded control word and destination register each cycle and carries them through the ID/EX, EX/MEM and MEM/WB control registers. It inserts bubbles on load-use stalls and invalid decode slots.
- Drives the E-stage and M-stage hazard/forwarding inputs (ewreg, em2reg, ern, mwreg, mm2reg, mrn) back to decode, plus the W-stage register-file write controls.
- Keeps saturating stall and retire counters for debug.

Parameters:
- CW, 16, width of stall_cnt and retire_cnt.
- JAL_RN, 31, destination register forced for jal.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- dvalid  in  1  ID stage holds a real instruction (0 = fetched slot squashed by if_flush).
- wpcir  in  1  0 = load-use stall this cycle.
- dwreg, dm2reg, dwmem, daluimm, dshift, djal  in  1 each  decoded controls.
- daluc  in  4  ALU op code.
- drn  in  5  decoded destination (rd or rt, already selected).
- clr_cnt  in  1  synchronous clear of both counters.
- ewreg, em2reg, ewmem, ealuimm, eshift, ejal  out  1 each  ID/EX register.
- ealuc  out  4  ID/EX register.
- ern  out  5  ID/EX register.
- evalid  out  1  ID/EX register.
- mwreg, mm2reg, mwmem, mvalid  out  1 each  EX/MEM register.
- mrn  out  5  EX/MEM register.
- wwreg, wm2reg, wvalid  out  1 each  MEM/WB register.
- wrn  out  5  MEM/WB register.
- stall_cnt  out  CW  cycles with wpcir=0.
- retire_cnt  out  CW  instructions that reached W.

Behaviour:
- Reset (async, any time including mid-stream): all outputs go to 0 immediately, and all three stages become bubbles.
- Bubble definition: every control bit 0, aluc 0, rn 0, valid 0.
- E-stage capture at posedge:
  - If dvalid=1 and wpcir=1: E takes the d* fields. ern is JAL_RN if djal=1, else drn. evalid=1.
  - Otherwise E is a bubble.
  - The stall squashes all fields regardless of dwreg/dwmem gating done upstream.
- M-stage capture at posedge: M takes E (wreg, m2reg, wmem, rn, valid) unconditionally. The pipeline never freezes past E, so a stall bubble propagates downstream.
- W-stage capture at posedge: W takes M (wreg, m2reg, rn, valid) unconditionally.
- Latency: a decoded instruction appears at E 1 cycle after capture, at M after 2, and at W after 3.
- The $zero destination is carried as-is. Decode suppresses hazards on rn=0, and the register file ignores writes to 0.
- stall_cnt: +1 at each posedge where wpcir=0.
- retire_cnt: +1 at each posedge where wvalid=1 (counts the instruction leaving W).
- Counter width and saturation: both counters are CW bits and saturate at 2^CW-1 (no wrap).
- clr_cnt=1: both counters become 0 at the posedge. Clear has priority over a simultaneous increment.
- wpcir=0 together with dvalid=0: one bubble, and stall_cnt still increments.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset mid-run:
  - Stimulus: stream of valid add instructions, assert reset asynchronously between edges.
  - Response: all outputs 0 before the next edge. After release, the first captured instruction shows evalid=1 one cycle later.
- Straight-line flow:
  - Stimulus: dvalid=1, wpcir=1, dwreg=1, drn=5, daluc=4'b0100, held for 1 cycle, then bubbles.
  - Response: ern=5 and ealuc=0100 at +1; mrn=5, mwreg=1 at +2; wrn=5, wwreg=1 at +3; retire_cnt=1 after +4.
- Load-use stall:
  - Stimulus: lw (dm2reg=1, drn=8), then a dependent add with wpcir=0 for one cycle, then wpcir=1.
  - Response: the E stage after the stall cycle is a bubble (ewreg=0, ern=0, evalid=0); the add reaches E one cycle later; stall_cnt=1.
- jal destination:
  - Stimulus: djal=1, dwreg=1, drn=0.
  - Response: ern=31 and ejal=1 at +1; wrn=31 at +3.
- Squashed slot:
  - Stimulus: dvalid=0 with dwreg=1, dwmem=1, drn=9.
  - Response: E all zero; retire_cnt unchanged 3 cycles later.
- Counter boundary:
  - Stimulus: CW=4, hold wpcir=0 for 20 cycles, then clr_cnt=1 in the same cycle wpcir=0.
  - Response: stall_cnt saturates at 15, then reads 0 after the clear edge.

Source files
------------

// File: rtl/pipe_ctrl_pipeline.sv
// rtl/pipe_ctrl_pipeline.sv - ID/EX, EX/MEM, MEM/WB control registers with bubble insertion and debug counters
module pipe_ctrl_pipeline #(
  parameter int          CW     = 16,
  parameter logic [4:0]  JAL_RN = 5'd31
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dvalid,
  input  logic          wpcir,
  input  logic          dwreg,
  input  logic          dm2reg,
  input  logic          dwmem,
  input  logic          daluimm,
  input  logic          dshift,
  input  logic          djal,
  input  logic [3:0]    daluc,
  input  logic [4:0]    drn,
  input  logic          clr_cnt,
  output logic          ewreg,
  output logic          em2reg,
  output logic          ewmem,
  output logic          ealuimm,
  output logic          eshift,
  output logic          ejal,
  output logic [3:0]    ealuc,
  output logic [4:0]    ern,
  output logic          evalid,
  output logic          mwreg,
  output logic          mm2reg,
  output logic          mwmem,
  output logic          mvalid,
  output logic [4:0]    mrn,
  output logic          wwreg,
  output logic          wm2reg,
  output logic          wvalid,
  output logic [4:0]    wrn,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] retire_cnt
);

  // A real, unstalled decode slot is the only thing that enters E; anything else is a bubble
  logic take;
  assign take = dvalid & wpcir;

  // ID/EX register: capture decoded controls or insert a bubble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ewreg   <= 1'b0;
      em2reg  <= 1'b0;
      ewmem   <= 1'b0;
      ealuimm <= 1'b0;
      eshift  <= 1'b0;
      ejal    <= 1'b0;
      ealuc   <= 4'd0;
      ern     <= 5'd0;
      evalid  <= 1'b0;
    end else if (take) begin
      ewreg   <= dwreg;
      em2reg  <= dm2reg;
      ewmem   <= dwmem;
      ealuimm <= daluimm;
      eshift  <= dshift;
      ejal    <= djal;
      ealuc   <= daluc;
      ern     <= djal ? JAL_RN : drn;
      evalid  <= 1'b1;
    end else begin
      ewreg   <= 1'b0;
      em2reg  <= 1'b0;
      ewmem   <= 1'b0;
      ealuimm <= 1'b0;
      eshift  <= 1'b0;
      ejal    <= 1'b0;
      ealuc   <= 4'd0;
      ern     <= 5'd0;
      evalid  <= 1'b0;
    end
  end

  // EX/MEM register: never freezes, so bubbles flow straight through
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
      mrn    <= 5'd0;
      mvalid <= 1'b0;
    end else begin
      mwreg  <= ewreg;
      mm2reg <= em2reg;
      mwmem  <= ewmem;
      mrn    <= ern;
      mvalid <= evalid;
    end
  end

  // MEM/WB register: register-file write controls for the W stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wrn    <= 5'd0;
      wvalid <= 1'b0;
    end else begin
      wwreg  <= mwreg;
      wm2reg <= mm2reg;
      wrn    <= mrn;
      wvalid <= mvalid;
    end
  end

  // Saturating debug counters; clear wins over a same-cycle increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      retire_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (!wpcir && stall_cnt != '1)
        stall_cnt <= stall_cnt + CW'(1);
      if (wvalid && retire_cnt != '1)
        retire_cnt <= retire_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_pipeline.sv
// tb/tb_pipe_ctrl_pipeline.sv - directed self-checking bench for pipe_ctrl_pipeline
module tb_pipe_ctrl_pipeline;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          dvalid = 1'b0, wpcir = 1'b1;
  logic          dwreg = 1'b0, dm2reg = 1'b0, dwmem = 1'b0;
  logic          daluimm = 1'b0, dshift = 1'b0, djal = 1'b0;
  logic [3:0]    daluc = 4'd0;
  logic [4:0]    drn = 5'd0;
  logic          clr_cnt = 1'b0;
  logic          ewreg, em2reg, ewmem, ealuimm, eshift, ejal, evalid;
  logic [3:0]    ealuc;
  logic [4:0]    ern, mrn, wrn;
  logic          mwreg, mm2reg, mwmem, mvalid;
  logic          wwreg, wm2reg, wvalid;
  logic [CW-1:0] stall_cnt, retire_cnt;

  int checks = 0;
  int failures = 0;

  pipe_ctrl_pipeline #(.CW(CW), .JAL_RN(5'd31)) dut (
    .clock(clock), .reset(reset), .dvalid(dvalid), .wpcir(wpcir),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm),
    .dshift(dshift), .djal(djal), .daluc(daluc), .drn(drn), .clr_cnt(clr_cnt),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm),
    .eshift(eshift), .ejal(ejal), .ealuc(ealuc), .ern(ern), .evalid(evalid),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem), .mvalid(mvalid), .mrn(mrn),
    .wwreg(wwreg), .wm2reg(wm2reg), .wvalid(wvalid), .wrn(wrn),
    .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic wp, input logic wr, input logic m2r,
                       input logic wm, input logic jal, input logic [3:0] aluc,
                       input logic [4:0] rn);
    dvalid = v; wpcir = wp; dwreg = wr; dm2reg = m2r; dwmem = wm;
    djal = jal; daluc = aluc; drn = rn; daluimm = 1'b0; dshift = 1'b0;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
  endtask

  initial begin
    // reset state
    #3;
    check_eq("rst_evalid", 32'(evalid), 32'd0);
    check_eq("rst_ern", 32'(ern), 32'd0);
    check_eq("rst_wvalid", 32'(wvalid), 32'd0);
    check_eq("rst_stall", 32'(stall_cnt), 32'd0);
    check_eq("rst_retire", 32'(retire_cnt), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // straight-line add
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 5'd5);
    tick();
    check_eq("sl_ern", 32'(ern), 32'd5);
    check_eq("sl_ealuc", 32'(ealuc), 32'h4);
    check_eq("sl_evalid", 32'(evalid), 32'd1);
    bubble();
    tick();
    check_eq("sl_mrn", 32'(mrn), 32'd5);
    check_eq("sl_mwreg", 32'(mwreg), 32'd1);
    check_eq("sl_ewreg_bub", 32'(ewreg), 32'd0);
    tick();
    check_eq("sl_wrn", 32'(wrn), 32'd5);
    check_eq("sl_wwreg", 32'(wwreg), 32'd1);
    check_eq("sl_wvalid", 32'(wvalid), 32'd1);
    tick();
    check_eq("sl_retire", 32'(retire_cnt), 32'd1);
    check_eq("sl_wvalid_clr", 32'(wvalid), 32'd0);

    // load-use stall
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd8);
    tick();
    check_eq("lu_em2reg", 32'(em2reg), 32'd1);
    check_eq("lu_ern_lw", 32'(ern), 32'd8);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 5'd9);
    tick();
    check_eq("lu_ewreg_bub", 32'(ewreg), 32'd0);
    check_eq("lu_ern_bub", 32'(ern), 32'd0);
    check_eq("lu_evalid_bub", 32'(evalid), 32'd0);
    check_eq("lu_mm2reg", 32'(mm2reg), 32'd1);
    check_eq("lu_mrn", 32'(mrn), 32'd8);
    check_eq("lu_stall", 32'(stall_cnt), 32'd1);
    wpcir = 1'b1;
    tick();
    check_eq("lu_ern_add", 32'(ern), 32'd9);
    check_eq("lu_evalid_add", 32'(evalid), 32'd1);
    check_eq("lu_ealuc_add", 32'(ealuc), 32'h2);
    bubble();
    tick(); tick(); tick();
    check_eq("lu_retire", 32'(retire_cnt), 32'd3);
    check_eq("lu_stall_hold", 32'(stall_cnt), 32'd1);

    // jal destination override
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 5'd0);
    tick();
    check_eq("jal_ern", 32'(ern), 32'd31);
    check_eq("jal_ejal", 32'(ejal), 32'd1);
    bubble();
    tick(); tick();
    check_eq("jal_wrn", 32'(wrn), 32'd31);
    tick();
    check_eq("jal_retire", 32'(retire_cnt), 32'd4);

    // squashed decode slot
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 5'd9);
    tick();
    check_eq("sq_ewreg", 32'(ewreg), 32'd0);
    check_eq("sq_ewmem", 32'(ewmem), 32'd0);
    check_eq("sq_ern", 32'(ern), 32'd0);
    check_eq("sq_evalid", 32'(evalid), 32'd0);
    tick(); tick(); tick();
    check_eq("sq_retire", 32'(retire_cnt), 32'd4);

    // asynchronous reset mid-stream
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd7);
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    check_eq("ar_evalid", 32'(evalid), 32'd0);
    check_eq("ar_mvalid", 32'(mvalid), 32'd0);
    check_eq("ar_wvalid", 32'(wvalid), 32'd0);
    check_eq("ar_ern", 32'(ern), 32'd0);
    check_eq("ar_stall", 32'(stall_cnt), 32'd0);
    check_eq("ar_retire", 32'(retire_cnt), 32'd0);
    #1 reset = 1'b0;
    tick();
    check_eq("ar_evalid_post", 32'(evalid), 32'd1);
    check_eq("ar_ern_post", 32'(ern), 32'd7);

    // stall counter saturation and clear priority
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd7);
    for (int i = 0; i < 20; i++) tick();
    check_eq("cnt_sat", 32'(stall_cnt), 32'd15);
    check_eq("cnt_retire_pre", 32'(retire_cnt), 32'd1);
    clr_cnt = 1'b1;
    tick();
    check_eq("cnt_clr_stall", 32'(stall_cnt), 32'd0);
    check_eq("cnt_clr_retire", 32'(retire_cnt), 32'd0);
    clr_cnt = 1'b0;
    tick();
    check_eq("cnt_resume", 32'(stall_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
